// File: rtl/past_tap_pkg.sv
// Shared defaults and sizing helper for the past-value tap and related monitor blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package past_tap_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  // Width of a select/count that must represent every value 0..depth inclusive.
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at MAX, with a synchronous clear that wins over increment.
// Latency: count visible one clk after the increment edge.
// Backpressure: none; increments at MAX are absorbed silently.
module sat_counter #(
  parameter int W   = 3,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: clear first, otherwise step up until the ceiling is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/past_value_tap.sv
// Synthesizable $past(din, N, gate): gated shift history with run-time look-back select.
// Latency: a sample taken at a gated edge is readable at sel=1 right after that edge; outputs are combinational.
// Backpressure: none; the tap is a passive observer and samples on every gated edge.
module past_value_tap
  import past_tap_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SELW  = sel_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             gate_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic [SELW-1:0]  sel_i,
  output logic [WIDTH-1:0] past_o,
  output logic             past_valid_o,
  output logic             sel_err_o,
  output logic [SELW-1:0]  fill_o,
  output logic             stable_o,
  output logic             changed_o
);

  // hist_q[0] is the most recent gated sample, hist_q[DEPTH-1] the oldest.
  logic [DEPTH-1:0][WIDTH-1:0] hist_d;
  logic [DEPTH-1:0][WIDTH-1:0] hist_q;
  logic [SELW-1:0]             fill;

  // History update: flush on clear (dropping any simultaneous sample), shift on gate, else hold.
  always_comb begin
    hist_d = hist_q;
    if (clear_i) begin
      hist_d = '0;
    end else if (gate_i) begin
      hist_d[0] = din_i;
      for (int k = 1; k < DEPTH; k++) begin
        hist_d[k] = hist_q[k-1];
      end
    end
  end

  // History register; reset reads back as zeros, the same default $past gives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  // Number of valid entries; only gated edges count, clear restarts from zero.
  sat_counter #(
    .W   (SELW),
    .MAX (DEPTH)
  ) u_fill (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clear_i),
    .inc_i (gate_i),
    .cnt_o (fill)
  );

  // Look-back mux: sel=0 is a pass-through, out-of-range selects read as invalid zero.
  always_comb begin
    past_o       = '0;
    past_valid_o = 1'b0;
    sel_err_o    = (sel_i > SELW'(DEPTH));
    if (sel_i == '0) begin
      past_o       = din_i;
      past_valid_o = 1'b1;
    end else if (!sel_err_o) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (sel_i == SELW'(k + 1)) begin
          past_o = hist_q[k];
        end
      end
      past_valid_o = (fill >= sel_i);
    end
  end

  // Stable/changed compare the live input with the newest sample; both quiet until one exists.
  always_comb begin
    stable_o  = 1'b0;
    changed_o = 1'b0;
    if (fill != '0) begin
      stable_o  = (din_i == hist_q[0]);
      changed_o = (din_i != hist_q[0]);
    end
  end

  assign fill_o = fill;

endmodule

// File: tb/tb_past_value_tap.sv
module tb_past_value_tap;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int SELW  = 3;

  logic             clk;
  logic             rst_n;
  logic             clear_i;
  logic             gate_i;
  logic [WIDTH-1:0] din_i;
  logic [SELW-1:0]  sel_i;
  logic [WIDTH-1:0] past_o;
  logic             past_valid_o;
  logic             sel_err_o;
  logic [SELW-1:0]  fill_o;
  logic             stable_o;
  logic             changed_o;

  int checks;
  int errors;

  past_value_tap #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (clear_i),
    .gate_i       (gate_i),
    .din_i        (din_i),
    .sel_i        (sel_i),
    .past_o       (past_o),
    .past_valid_o (past_valid_o),
    .sel_err_o    (sel_err_o),
    .fill_o       (fill_o),
    .stable_o     (stable_o),
    .changed_o    (changed_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges, leaving inputs idle.
  task automatic apply_reset();
    clear_i = 1'b0;
    gate_i  = 1'b0;
    din_i   = '0;
    sel_i   = 3'd1;
    rst_n   = 1'b0;
    #3;
    rst_n   = 1'b1;
    #1;
  endtask

  // Gate in one sample per edge.
  task automatic push(input logic [WIDTH-1:0] v);
    gate_i = 1'b1;
    din_i  = v;
    tick();
    gate_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_i = 1'b0;
    gate_i  = 1'b1;
    din_i   = 4'h5;
    sel_i   = 3'd1;
    rst_n   = 1'b0;
    tick();
    tick();
    checks++;
    if (past_o !== 4'h0) begin errors++; $display("FAIL reset_past: got %h want 0", past_o); end
    checks++;
    if (past_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", past_valid_o); end
    checks++;
    if (fill_o !== 3'd0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_o); end
    checks++;
    if (stable_o !== 1'b0 || changed_o !== 1'b0) begin
      errors++; $display("FAIL reset_stable_changed: got %b%b want 00", stable_o, changed_o);
    end
    sel_i = 3'd0;
    #1;
    checks++;
    if (past_o !== 4'h5 || past_valid_o !== 1'b1) begin
      errors++; $display("FAIL reset_sel0: got %h/%b want 5/1", past_o, past_valid_o);
    end
    gate_i = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic test_full_history();
    logic [WIDTH-1:0] vals [5] = '{4'h3, 4'h7, 4'hA, 4'h5, 4'hC};
    logic [WIDTH-1:0] exp  [4] = '{4'hC, 4'h5, 4'hA, 4'h7};
    apply_reset();
    for (int i = 0; i < 5; i++) push(vals[i]);
    for (int s = 1; s <= 4; s++) begin
      sel_i = SELW'(s);
      #1;
      checks++;
      if (past_o !== exp[s-1] || past_valid_o !== 1'b1) begin
        errors++; $display("FAIL full_sel%0d: got %h/%b want %h/1", s, past_o, past_valid_o, exp[s-1]);
      end
    end
    checks++;
    if (fill_o !== 3'd4) begin errors++; $display("FAIL full_fill: got %0d want 4", fill_o); end
  endtask

  task automatic test_single_sample();
    apply_reset();
    push(4'h9);
    sel_i = 3'd1;
    #1;
    checks++;
    if (past_o !== 4'h9 || past_valid_o !== 1'b1) begin
      errors++; $display("FAIL single_sel1: got %h/%b want 9/1", past_o, past_valid_o);
    end
    sel_i = 3'd2;
    #1;
    checks++;
    if (past_o !== 4'h0 || past_valid_o !== 1'b0) begin
      errors++; $display("FAIL single_sel2: got %h/%b want 0/0", past_o, past_valid_o);
    end
    sel_i = 3'd3;
    #1;
    checks++;
    if (past_valid_o !== 1'b0) begin errors++; $display("FAIL single_sel3_valid: got %b want 0", past_valid_o); end
    checks++;
    if (fill_o !== 3'd1) begin errors++; $display("FAIL single_fill: got %0d want 1", fill_o); end
  endtask

  task automatic test_gating();
    logic [WIDTH-1:0] vals  [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    logic             gates [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      gate_i = gates[i];
      din_i  = vals[i];
      tick();
    end
    gate_i = 1'b0;
    sel_i  = 3'd1;
    #1;
    checks++;
    if (past_o !== 4'h3) begin errors++; $display("FAIL gate_sel1: got %h want 3", past_o); end
    sel_i = 3'd2;
    #1;
    checks++;
    if (past_o !== 4'h1 || past_valid_o !== 1'b1) begin
      errors++; $display("FAIL gate_sel2: got %h/%b want 1/1", past_o, past_valid_o);
    end
    checks++;
    if (fill_o !== 3'd2) begin errors++; $display("FAIL gate_fill: got %0d want 2", fill_o); end
    sel_i = 3'd3;
    #1;
    checks++;
    if (past_valid_o !== 1'b0) begin errors++; $display("FAIL gate_sel3_valid: got %b want 0", past_valid_o); end
  endtask

  task automatic test_clear();
    apply_reset();
    for (int i = 1; i <= 4; i++) push(WIDTH'(i));
    clear_i = 1'b1;
    gate_i  = 1'b1;
    din_i   = 4'hF;
    tick();
    clear_i = 1'b0;
    gate_i  = 1'b0;
    checks++;
    if (fill_o !== 3'd0) begin errors++; $display("FAIL clear_fill: got %0d want 0", fill_o); end
    for (int s = 1; s <= 4; s++) begin
      sel_i = SELW'(s);
      #1;
      checks++;
      if (past_o !== 4'h0 || past_valid_o !== 1'b0) begin
        errors++; $display("FAIL clear_sel%0d: got %h/%b want 0/0", s, past_o, past_valid_o);
      end
    end
    push(4'h6);
    sel_i = 3'd1;
    #1;
    checks++;
    if (past_o !== 4'h6 || past_valid_o !== 1'b1) begin
      errors++; $display("FAIL clear_refill: got %h/%b want 6/1", past_o, past_valid_o);
    end
    checks++;
    if (fill_o !== 3'd1) begin errors++; $display("FAIL clear_refill_fill: got %0d want 1", fill_o); end
  endtask

  task automatic test_sel_err();
    apply_reset();
    push(4'hA); push(4'hB); push(4'hC); push(4'hD);
    sel_i = 3'd5;
    #1;
    checks++;
    if (sel_err_o !== 1'b1 || past_o !== 4'h0 || past_valid_o !== 1'b0) begin
      errors++; $display("FAIL selerr_5: got err=%b past=%h valid=%b want 1/0/0", sel_err_o, past_o, past_valid_o);
    end
    tick();
    sel_i = 3'd7;
    #1;
    checks++;
    if (sel_err_o !== 1'b1 || past_o !== 4'h0) begin
      errors++; $display("FAIL selerr_7: got err=%b past=%h want 1/0", sel_err_o, past_o);
    end
    tick();
    sel_i = 3'd2;
    #1;
    checks++;
    if (sel_err_o !== 1'b0 || past_o !== 4'hC || past_valid_o !== 1'b1) begin
      errors++; $display("FAIL selerr_back2: got err=%b past=%h valid=%b want 0/C/1", sel_err_o, past_o, past_valid_o);
    end
    sel_i = 3'd4;
    #1;
    checks++;
    if (sel_err_o !== 1'b0 || past_o !== 4'hA || past_valid_o !== 1'b1) begin
      errors++; $display("FAIL selerr_sel4: got err=%b past=%h valid=%b want 0/A/1", sel_err_o, past_o, past_valid_o);
    end
  endtask

  task automatic test_async_reset_stable();
    apply_reset();
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    sel_i = 3'd1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (past_o !== 4'h0 || past_valid_o !== 1'b0 || fill_o !== 3'd0) begin
      errors++; $display("FAIL async_reset: got past=%h valid=%b fill=%0d want 0/0/0", past_o, past_valid_o, fill_o);
    end
    rst_n = 1'b1;
    din_i = 4'h8;
    #1;
    checks++;
    if (stable_o !== 1'b0 || changed_o !== 1'b0) begin
      errors++; $display("FAIL empty_stable_changed: got %b%b want 00", stable_o, changed_o);
    end
    tick();
    push(4'h8);
    push(4'h8);
    checks++;
    if (stable_o !== 1'b1 || changed_o !== 1'b0) begin
      errors++; $display("FAIL stable_8: got stable=%b changed=%b want 1/0", stable_o, changed_o);
    end
    din_i = 4'h9;
    #1;
    checks++;
    if (stable_o !== 1'b0 || changed_o !== 1'b1) begin
      errors++; $display("FAIL changed_9: got stable=%b changed=%b want 0/1", stable_o, changed_o);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    clear_i = 1'b0;
    gate_i  = 1'b0;
    din_i   = '0;
    sel_i   = '0;
    test_reset();
    test_full_history();
    test_single_sample();
    test_gating();
    test_clear();
    test_sel_err();
    test_async_reset_stable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
